// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared definitions for the multi-cycle ALU.
//   - REG_FILE_WIDTH : default datapath width, matches the register file
//   - ALU_* opcodes  : 5-bit opcode map (0..14 defined, 15..31 illegal)
//   - alu_state_e    : FSM state encoding used by alu_mc
//   - op_is_divide() : true for the divider opcodes (DIV/REM)
`timescale 1ns/1ps
package alu_mc_pkg;

  localparam int REG_FILE_WIDTH = 32;
  localparam int OP_W           = 5;

  localparam logic [OP_W-1:0] ALU_ADD = 5'd0;
  localparam logic [OP_W-1:0] ALU_SUB = 5'd1;
  localparam logic [OP_W-1:0] ALU_MUL = 5'd2;
  localparam logic [OP_W-1:0] ALU_OR  = 5'd3;
  localparam logic [OP_W-1:0] ALU_AND = 5'd4;
  localparam logic [OP_W-1:0] ALU_XOR = 5'd5;
  localparam logic [OP_W-1:0] ALU_SLL = 5'd6;
  localparam logic [OP_W-1:0] ALU_SRL = 5'd7;
  localparam logic [OP_W-1:0] ALU_MV  = 5'd8;
  localparam logic [OP_W-1:0] ALU_LT  = 5'd9;
  localparam logic [OP_W-1:0] ALU_GT  = 5'd10;
  localparam logic [OP_W-1:0] ALU_EQ  = 5'd11;
  localparam logic [OP_W-1:0] ALU_JMP = 5'd12;
  localparam logic [OP_W-1:0] ALU_DIV = 5'd13;
  localparam logic [OP_W-1:0] ALU_REM = 5'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic op_is_divide(logic [OP_W-1:0] op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

endpackage

// File: rtl/alu_iter_div.sv
// alu_iter_div: iterative unsigned restoring divider, one quotient bit per
// clock, WIDTH clocks per divide.
//   clk, reset   : clock, synchronous active-high reset (aborts a divide)
//   start_i      : load dividend/divisor and begin (ignored if divisor is 0)
//   dividend_i   : dividend sampled on start_i
//   divisor_i    : divisor sampled on start_i
//   done_o       : high during the final iteration cycle
//   quotient_o   : final quotient, valid while done_o is high
//   remainder_o  : final remainder, valid while done_o is high
//   div0_o       : start_i offered with a zero divisor; no divide is run
// Only built into alu_mc when ALU_DIV_EN is defined.
`timescale 1ns/1ps
module alu_iter_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div0_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;

  logic [WIDTH:0]   shifted_d;
  logic [WIDTH:0]   trial_d;
  logic             qbit_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;

  // The dividend is shifted out of quo_q MSB-first into the partial
  // remainder while quotient bits are shifted in at the bottom. The extra
  // top bit keeps the trial subtraction exact when the shifted remainder
  // reaches 2^WIDTH.
  always_comb begin
    shifted_d = {rem_q, quo_q[WIDTH-1]};
    trial_d   = shifted_d - {1'b0, dsr_q};
    qbit_d    = ~trial_d[WIDTH];
    rem_d     = qbit_d ? trial_d[WIDTH-1:0] : shifted_d[WIDTH-1:0];
    quo_d     = {quo_q[WIDTH-2:0], qbit_d};
  end

  assign div0_o      = start_i && (divisor_i == '0);
  // Results are taken straight from the last step so the consumer can
  // latch them on the same edge that retires the divide.
  assign done_o      = busy_q && (cnt_q == '0);
  assign quotient_o  = quo_d;
  assign remainder_o = rem_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
    end else if (start_i && !div0_o) begin
      busy_q <= 1'b1;
      cnt_q  <= CNT_LOAD;
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dsr_q  <= divisor_i;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU between issue and writeback with valid/ready
// handshakes on both sides. Single-cycle ops complete one clock after
// accept; MUL (and DIV/REM when enabled) iterate for WIDTH clocks.
//   clk, reset   : clock, synchronous active-high reset
//   in_valid     : operation offered          in_ready  : can accept now
//   in_op        : 5-bit opcode                in_tag    : returned unchanged
//   in_x, in_y   : operands (latched at accept)
//   out_valid    : result held valid           out_ready : consumer accepts
//   out_w        : result word                 out_cmp   : relational result
//   out_tag      : tag of completed op         out_illegal : unknown/disabled op
//   out_div0     : divide/remainder by zero
// Build option: define ALU_DIV_EN to instantiate alu_iter_div for opcodes
// 13/14; without it those opcodes complete as illegal ops.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no result pending, ready for a new op
// ST_BUSY | MUL or DIV/REM iterating, in_ready low
// ST_DONE | result registered and presented until out_ready
`timescale 1ns/1ps
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH   = REG_FILE_WIDTH,
  parameter int TAG_W   = 4,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_w,
  output logic             out_cmp,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic             out_div0
);

  localparam logic [SHAMT_W-1:0] CNT_LOAD = SHAMT_W'(WIDTH - 1);

  alu_state_e       state_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [4:0]       iter_op_q;
  logic [WIDTH-1:0] mul_acc_q;
  logic [WIDTH-1:0] mul_x_q;
  logic [WIDTH-1:0] mul_y_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_w_q;
  logic             out_cmp_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             out_ill_q;
  logic             out_div0_q;

  logic             accept;
  logic [SHAMT_W-1:0] shamt;
  logic             shift_oob;
  logic [WIDTH-1:0] res_w_d;
  logic             res_cmp_d;
  logic             res_ill_d;
  logic             res_div0_d;
  logic             res_iter_d;
  logic [WIDTH-1:0] mul_acc_d;

  // A held result frees the input side in the same cycle it is consumed,
  // which gives back-to-back single-cycle throughput.
  assign in_ready = (state_q != ST_BUSY) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign shamt     = in_y[SHAMT_W-1:0];
  assign shift_oob = |(in_y >> SHAMT_W);

`ifdef ALU_DIV_EN
  logic             div_start;
  logic             div_done;
  logic             div_div0;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  assign div_start = accept && op_is_divide(in_op);

  alu_iter_div #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (div_start),
    .dividend_i (in_x),
    .divisor_i  (in_y),
    .done_o     (div_done),
    .quotient_o (div_quo),
    .remainder_o(div_rem),
    .div0_o     (div_div0)
  );
`endif

  always_comb begin
    res_w_d    = '0;
    res_cmp_d  = 1'b0;
    res_ill_d  = 1'b0;
    res_div0_d = 1'b0;
    res_iter_d = 1'b0;
    case (in_op)
      ALU_ADD: res_w_d = in_x + in_y;
      ALU_SUB: res_w_d = in_x - in_y;
      ALU_MUL: res_iter_d = 1'b1;
      ALU_OR:  res_w_d = in_x | in_y;
      ALU_AND: res_w_d = in_x & in_y;
      ALU_XOR: res_w_d = in_x ^ in_y;
      ALU_SLL: res_w_d = shift_oob ? '0 : (in_x << shamt);
      ALU_SRL: res_w_d = shift_oob ? '0 : (in_x >> shamt);
      ALU_MV:  res_w_d = in_x;
      ALU_LT:  res_cmp_d = (in_x < in_y);
      ALU_GT:  res_cmp_d = (in_x > in_y);
      ALU_EQ:  res_cmp_d = (in_x == in_y);
      ALU_JMP: res_w_d = in_x + in_y;
`ifdef ALU_DIV_EN
      ALU_DIV, ALU_REM: begin
        // Zero divisor short-circuits to a one-cycle result.
        if (div_div0) begin
          res_div0_d = 1'b1;
          res_w_d    = (in_op == ALU_DIV) ? '1 : in_x;
        end else begin
          res_iter_d = 1'b1;
        end
      end
`endif
      default: res_ill_d = 1'b1;
    endcase
  end

  // Radix-2 shift-add: add the shifted multiplicand when the current
  // multiplier LSB is set.
  assign mul_acc_d = mul_acc_q + (mul_y_q[0] ? mul_x_q : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      iter_op_q   <= ALU_ADD;
      mul_acc_q   <= '0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      out_valid_q <= 1'b0;
      out_w_q     <= '0;
      out_cmp_q   <= 1'b0;
      out_tag_q   <= '0;
      out_ill_q   <= 1'b0;
      out_div0_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_BUSY: begin
          if (iter_op_q == ALU_MUL) begin
            mul_acc_q <= mul_acc_d;
            mul_x_q   <= mul_x_q << 1;
            mul_y_q   <= mul_y_q >> 1;
            if (cnt_q == '0) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              out_w_q     <= mul_acc_d;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
`ifdef ALU_DIV_EN
          else if (div_done) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            out_w_q     <= (iter_op_q == ALU_DIV) ? div_quo : div_rem;
          end
`endif
        end
        default: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
          if (accept) begin
            out_tag_q  <= in_tag;
            out_cmp_q  <= res_cmp_d;
            out_ill_q  <= res_ill_d;
            out_div0_q <= res_div0_d;
            if (res_iter_d) begin
              state_q     <= ST_BUSY;
              out_valid_q <= 1'b0;
              iter_op_q   <= in_op;
              cnt_q       <= CNT_LOAD;
              mul_acc_q   <= '0;
              mul_x_q     <= in_x;
              mul_y_q     <= in_y;
            end else begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              out_w_q     <= res_w_d;
            end
          end
        end
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_w       = out_w_q;
  assign out_cmp     = out_cmp_q;
  assign out_tag     = out_tag_q;
  assign out_illegal = out_ill_q;
  assign out_div0    = out_div0_q;

endmodule

// File: tb/tb_alu_mc.sv
`timescale 1ns/1ps
module tb_alu_mc;

  localparam int W  = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_op = 5'd0;
  logic [W-1:0]  in_x = '0;
  logic [W-1:0]  in_y = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_w;
  logic          out_cmp;
  logic [TW-1:0] out_tag;
  logic          out_illegal;
  logic          out_div0;

  alu_mc #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_w      (out_w),
    .out_cmp    (out_cmp),
    .out_tag    (out_tag),
    .out_illegal(out_illegal),
    .out_div0   (out_div0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]  w;
    logic          cmp;
    logic [TW-1:0] tag;
    logic          ill;
    logic          div0;
  } exp_t;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] w;
    logic         cmp;
    logic         ill;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, req);
    end
  endtask

  task automatic add_vec(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] w, input logic cmp, input logic ill);
    vec_t v;
    v.op = op; v.x = x; v.y = y; v.w = w; v.cmp = cmp; v.ill = ill;
    vecs.push_back(v);
  endtask

  // Drives an op, waits for in_ready, and on the accepting edge pushes the
  // expected response. Returns at posedge+1 with in_valid still high.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [TW-1:0] tag, input logic [W-1:0] ew, input logic ecmp,
                       input logic eill, input logic ediv0, input bit push);
    exp_t e;
    int   k;
    in_valid = 1'b1; in_op = op; in_x = x; in_y = y; in_tag = tag;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout op=%0d: in_ready got 0, required 1", op);
    end
    @(posedge clk);
    if (push) begin
      e.w = ew; e.cmp = ecmp; e.tag = tag; e.ill = eill; e.div0 = ediv0;
      sb.push_back(e);
    end
    #1;
  endtask

  // Drop in_valid and scramble the operand bus so latching is exercised.
  task automatic idle();
    in_valid = 1'b0;
    in_op = 5'd31;
    in_x = 32'hBAD0_BAD0;
    in_y = 32'h0BAD_0BAD;
  endtask

  // Counts cycles from the accepting edge to out_valid; returns at posedge+1.
  task automatic wait_lat(input int req_lat, input string nm, output int low);
    int k;
    k = 1; low = 0;
    @(negedge clk);
    while (!out_valid && k < 200) begin
      if (!in_ready) low++;
      @(negedge clk);
      k++;
    end
    chk(nm, k, req_lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   low;
    int   t0;
    logic seen;

    fork
      forever begin
        @(negedge clk);
        if (!reset && out_valid && out_ready) begin
          exp_t e;
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_result: got w=0x%08h tag=%0d, required no result", out_w, out_tag);
          end else begin
            e = sb.pop_front();
            chk($sformatf("res_w tag=%0d", e.tag), out_w, e.w);
            chk($sformatf("res_cmp tag=%0d", e.tag), {31'd0, out_cmp}, {31'd0, e.cmp});
            chk($sformatf("res_tag tag=%0d", e.tag), {28'd0, out_tag}, {28'd0, e.tag});
            chk($sformatf("res_illegal tag=%0d", e.tag), {31'd0, out_illegal}, {31'd0, e.ill});
            chk($sformatf("res_div0 tag=%0d", e.tag), {31'd0, out_div0}, {31'd0, e.div0});
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_w", out_w, 32'd0);
    chk("rst_out_cmp", {31'd0, out_cmp}, 32'd0);
    chk("rst_out_tag", {28'd0, out_tag}, 32'd0);
    chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    chk("rst_out_div0", {31'd0, out_div0}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Single-cycle op table
    add_vec(5'd0,  32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 1'b0, 1'b0);
    add_vec(5'd1,  32'd0,         32'd1,        32'hFFFF_FFFF, 1'b0, 1'b0);
    add_vec(5'd3,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0);
    add_vec(5'd4,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1'b0);
    add_vec(5'd5,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0);
    add_vec(5'd6,  32'd1,         32'd31,       32'h8000_0000, 1'b0, 1'b0);
    add_vec(5'd6,  32'd1,         32'd32,       32'h0000_0000, 1'b0, 1'b0);
    add_vec(5'd7,  32'h8000_0000, 32'd31,       32'h0000_0001, 1'b0, 1'b0);
    add_vec(5'd7,  32'hFFFF_FFFF, 32'h0000_0100, 32'h0000_0000, 1'b0, 1'b0);
    add_vec(5'd8,  32'hDEAD_BEEF, 32'h0000_1234, 32'hDEAD_BEEF, 1'b0, 1'b0);
    add_vec(5'd9,  32'd9,         32'd3,        32'd0,         1'b0, 1'b0);
    add_vec(5'd10, 32'h8000_0000, 32'd1,        32'd0,         1'b1, 1'b0);
    add_vec(5'd11, 32'd5,         32'd5,        32'd0,         1'b1, 1'b0);
    add_vec(5'd11, 32'd5,         32'd6,        32'd0,         1'b0, 1'b0);
    add_vec(5'd12, 32'h0000_1000, 32'h0000_0024, 32'h0000_1024, 1'b0, 1'b0);
    add_vec(5'd15, 32'd7,         32'd7,        32'd0,         1'b0, 1'b1);
    add_vec(5'd20, 32'h1234_5678, 32'd1,        32'd0,         1'b0, 1'b1);
    add_vec(5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,        1'b0, 1'b1);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].x, vecs[i].y, TW'(i + 3), vecs[i].w, vecs[i].cmp, vecs[i].ill, 1'b0, 1'b1);
      idle();
      wait_lat(1, $sformatf("lat1 op=%0d", vecs[i].op), low);
    end

    // Same table back-to-back: one accept per clock
    t0 = cyc;
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].x, vecs[i].y, TW'(i), vecs[i].w, vecs[i].cmp, vecs[i].ill, 1'b0, 1'b1);
    end
    chk("b2b_cycles", cyc - t0, vecs.size());
    idle();
    repeat (3) @(posedge clk); #1;

    // Multiply
    issue(5'd2, 32'h0001_0003, 32'h0000_0005, 4'd7, 32'h0005_000F, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    wait_lat(33, "mul_latency", low);
    chk("mul_in_ready_low_cycles", low, 32'd32);
    issue(5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd8, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    wait_lat(33, "mul2_latency", low);

    // Divide / remainder
`ifdef ALU_DIV_EN
    issue(5'd13, 32'd100, 32'd7, 4'd9, 32'd14, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    wait_lat(33, "div_latency", low);
    issue(5'd14, 32'd100, 32'd7, 4'd10, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    wait_lat(33, "rem_latency", low);
    issue(5'd13, 32'hFFFF_FFFF, 32'd1, 4'd11, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    wait_lat(33, "div_big_latency", low);
    issue(5'd14, 32'd7, 32'd100, 4'd12, 32'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    wait_lat(33, "rem_small_latency", low);
    issue(5'd13, 32'd9, 32'd0, 4'd13, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    wait_lat(1, "div0_latency", low);
    issue(5'd14, 32'd9, 32'd0, 4'd14, 32'd9, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    wait_lat(1, "rem0_latency", low);
`else
    issue(5'd13, 32'd100, 32'd7, 4'd9, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();
    wait_lat(1, "div_disabled_latency", low);
    issue(5'd14, 32'd100, 32'd7, 4'd10, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();
    wait_lat(1, "rem_disabled_latency", low);
    issue(5'd13, 32'd9, 32'd0, 4'd13, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();
    wait_lat(1, "div0_disabled_latency", low);
`endif

    // Backpressure then release with a new op in the same cycle
    out_ready = 1'b0;
    issue(5'd9, 32'd3, 32'd9, 4'd5, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle();
    wait_lat(1, "lt_latency", low);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_valid c%0d", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp_cmp c%0d", i), {31'd0, out_cmp}, 32'd1);
      chk($sformatf("bp_tag c%0d", i), {28'd0, out_tag}, 32'd5);
      chk($sformatf("bp_in_ready c%0d", i), {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 5'd6; in_x = 32'd1; in_y = 32'd40; in_tag = 4'd6;
    @(negedge clk);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    begin
      exp_t e;
      e.w = 32'd0; e.cmp = 1'b0; e.tag = 4'd6; e.ill = 1'b0; e.div0 = 1'b0;
      if (in_ready) sb.push_back(e);
    end
    #1;
    idle();
    @(negedge clk);
    chk("no_bubble_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    repeat (2) @(posedge clk); #1;

    // Reset in the middle of a multiply
    issue(5'd2, 32'd3, 32'd5, 4'd2, 32'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_never_valid", {31'd0, seen}, 32'd0);

    // Operation after abort still works
    @(posedge clk); #1;
    issue(5'd0, 32'd40, 32'd2, 4'd15, 32'd42, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    wait_lat(1, "post_abort_latency", low);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Multi-cycle, parametrised successor to the core ALU. Sits between the decode/issue stage and writeback, with a valid/ready handshake on both sides. Keeps the existing 5-bit opcode map and adds iterative multiply and unsigned divide/remainder. Adds registered outputs, a busy state and an illegal-op flag.

Parameters:
WIDTH, 32, operand/result width in bits (≥ 8, power of two)
TAG_W, 4, width of the issue tag carried alongside each operation
SHAMT_W, $clog2(WIDTH), significant shift-amount bits

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
in_valid  in  1  operation offered
in_ready  out  1  block can accept an operation this cycle
in_op  in  5  opcode
in_x  in  WIDTH  operand x
in_y  in  WIDTH  operand y
in_tag  in  TAG_W  issue tag, returned unchanged
out_valid  out  1  result held valid
out_ready  in  1  consumer accepts result
out_w  out  WIDTH  result word
out_cmp  out  1  relational result
out_tag  out  TAG_W  tag of the completed op
out_illegal  out  1  opcode unknown or disabled
out_div0  out  1  divide/remainder by zero

Behaviour:
- One clock; synchronous active-high reset.
- On reset: in_ready=1, out_valid=0, and out_w, out_cmp, out_tag, out_illegal and out_div0 all 0. FSM goes to IDLE and the iteration counter clears.
- An operation is accepted when in_valid && in_ready.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. A single-cycle op goes to DONE on the next edge. MUL/DIV/REM go to BUSY.
  - BUSY: in_ready=0. The counter runs WIDTH cycles, then the FSM goes to DONE.
  - DONE: out_valid=1 and outputs are stable. When out_ready=1, the FSM goes to IDLE. If in_valid is also high in that same cycle, the new op is accepted, so a back-to-back single-cycle op reaches DONE again on the next edge (throughput 1/cycle). in_ready = !out_valid || out_ready when the FSM is not in BUSY.
- Latency from accept to out_valid:
  - 1 cycle: ops 0-12 and illegal ops.
  - WIDTH+1 cycles: MUL 2, DIV 13, REM 14.
- Opcodes:
  - 0 ADD, 1 SUB: wrap modulo 2^WIDTH.
  - 2 MUL: low WIDTH bits of the product, radix-2 shift-add.
  - 3 OR, 4 AND, 5 XOR.
  - 6 SLL, 7 SRL: logical shifts. If in_y ≥ WIDTH, out_w=0.
  - 8 MV: out_w=x.
  - 9 LT, 10 GT, 11 EQ: unsigned. Set out_cmp; out_w=0.
  - 12 JMP: out_w=x+y.
  - 13 DIV, 14 REM: unsigned, restoring divide.
  - For non-compare ops, out_cmp=0.
- Divide by zero: no iteration, 1-cycle latency, out_div0=1. DIV returns all-ones; REM returns x.
- Illegal op (15-31, or 13/14 when disabled): 1-cycle latency, out_w=0, out_illegal=1.
- Reset asserted during BUSY or DONE aborts the op and discards the result; the result is never presented.
- in_* are ignored while in_ready=0. Operands are latched at accept, so the upstream may change them afterwards.

Optional Feature:
ALU_DIV_EN
- Defined: opcodes 13/14 are implemented via the iterative divider sub-module.
- Undefined: the divider is not instantiated; 13/14 are treated as illegal ops (out_illegal=1, 1-cycle latency).
- MUL is unaffected in both cases.

Decomposition:
- Shared header/package: opcode localparams (ALU_ADD … ALU_REM), FSM state encodings, and the default width tied to REG_FILE_WIDTH.
- One natural sub-module: alu_iter_div. Parametrised WIDTH, with start/done, quotient, remainder and div0 outputs; it owns its own counter.
- MUL iteration stays in alu_mc.

Test Plan:
1. Reset, then ADD x=0xFFFF_FFFF, y=2, tag=3 -> out_valid 1 cycle later; out_w=0x0000_0001, out_tag=3, out_cmp=0.
2. MUL x=0x0001_0003, y=0x0000_0005 -> in_ready=0 for 32 cycles; out_w=0x0005_000F at cycle 33.
3. DIV x=100, y=7 -> out_w=14; REM x=100, y=7 -> out_w=2; DIV x=9, y=0 -> out_w=0xFFFF_FFFF, out_div0=1 after 1 cycle (ALU_DIV_EN defined). Without ALU_DIV_EN, DIV -> out_illegal=1.
4. Backpressure: out_ready=0 for 5 cycles after LT x=3, y=9 -> out_cmp=1 held stable and in_ready=0. Release out_ready with in_valid high (SLL x=1, y=40) -> next result is out_w=0 with no bubble.
5. Opcode 20 -> out_illegal=1, out_w=0. Reset mid-MUL at cycle 10 -> out_valid never asserts and in_ready=1 on the cycle after reset.
